// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard/stall controller.
package hazard_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, MDU_WAIT} state_e;
  localparam int CNT_W = 4;
  localparam int PERF_W = 32;
  localparam int X0 = 0;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: wrapping per-cycle counters for load stalls, MDU holds and flushes.
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_stall_i,
  input  logic              mdu_hold_i,
  input  logic              flush_i,
  output logic [PERF_W-1:0] perf_load_stall_o,
  output logic [PERF_W-1:0] perf_mdu_stall_o,
  output logic [PERF_W-1:0] perf_flush_o
);
  logic [PERF_W-1:0] ld_q, mdu_q, fl_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ld_q  <= '0;
      mdu_q <= '0;
      fl_q  <= '0;
    end else begin
      ld_q  <= ld_q + PERF_W'(ld_stall_i);
      mdu_q <= mdu_q + PERF_W'(mdu_hold_i);
      fl_q  <= fl_q + PERF_W'(flush_i);
    end
  end
  assign perf_load_stall_o = ld_q;
  assign perf_mdu_stall_o  = mdu_q;
  assign perf_flush_o      = fl_q;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / MDU / taken-branch stall and flush control for the 5-stage core.
// Optional STALL_PERF_CNT_EN adds three wrapping 32-bit stall/flush performance counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STALL = 1,
  parameter int MDU_LAT    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_memread_i,
  input  logic                  ex_mdu_start_i,
  input  logic                  ex_branch_taken_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  idex_hold_o,
  output logic                  exmem_bubble_o,
  output logic                  busy_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     perf_load_stall_o,
  output logic [PERF_W-1:0]     perf_mdu_stall_o,
  output logic [PERF_W-1:0]     perf_flush_o
`endif
);
  localparam bit LD_WAITS  = LOAD_STALL > 1;
  localparam bit MDU_HOLDS = MDU_LAT > 1;
  localparam bit MDU_WAITS = MDU_LAT > 2;
  localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'(LD_WAITS ? LOAD_STALL - 2 : 0);
  // Start cycle plus MDU_LAT-2 wait cycles; the wait state runs cnt down to 0 inclusive.
  localparam logic [CNT_W-1:0] MDU_INIT = CNT_W'(MDU_WAITS ? MDU_LAT - 3 : 0);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic idle, lu_haz, br_go, mdu_go, ld_go, ld_stall, mdu_hold;
  assign lu_haz = ex_memread_i & (ex_rd_i != REG_ADDR_W'(X0)) &
                  ((id_rs1_used_i & (ex_rd_i == id_rs1_i)) |
                   (id_rs2_used_i & (ex_rd_i == id_rs2_i)));
  // Gating with rst_i forces reset output values even while hazard inputs are live.
  assign idle     = rst_i & (state_q == IDLE);
  assign br_go    = idle & ex_branch_taken_i;
  assign mdu_go   = idle & ~ex_branch_taken_i & ex_mdu_start_i & MDU_HOLDS;
  assign ld_go    = idle & ~ex_branch_taken_i & ~mdu_go & lu_haz;
  assign ld_stall = ld_go | (rst_i & (state_q == LOAD_WAIT));
  assign mdu_hold = mdu_go | (rst_i & (state_q == MDU_WAIT));
  always_comb begin
    state_d = (state_q == IDLE) ? ((mdu_go && MDU_WAITS) ? MDU_WAIT :
                                   (ld_go && LD_WAITS) ? LOAD_WAIT : IDLE)
                                : ((cnt_q == '0) ? IDLE : state_q);
    cnt_d   = mdu_go ? MDU_INIT : ld_go ? LD_INIT :
              (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign pc_write_o     = ~(ld_stall | mdu_hold);
  assign ifid_write_o   = ~(ld_stall | mdu_hold);
  assign ifid_flush_o   = br_go;
  assign idex_bubble_o  = br_go | ld_stall;
  assign idex_hold_o    = mdu_hold;
  assign exmem_bubble_o = mdu_hold;
  assign busy_o         = state_q != IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      assert (!(ex_mdu_start_i && (ex_memread_i || ex_branch_taken_i)));
    end
  end
`ifdef STALL_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ld_stall_i        (ld_stall),
    .mdu_hold_i        (mdu_hold),
    .flush_i           (br_go),
    .perf_load_stall_o (perf_load_stall_o),
    .perf_mdu_stall_o  (perf_mdu_stall_o),
    .perf_flush_o      (perf_flush_o)
  );
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks of two controller instances (LOAD_STALL=1 and 3, MDU_LAT=4).
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, mdu, br;
  logic pc1, iw1, fl1, bb1, hd1, eb1, by1;
  logic pc3, iw3, fl3, bb3, hd3, eb3, by3;
  logic [6:0] o1, o3;
  int total = 0, bad = 0;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] pl1, pm1, pf1, pl3, pm3, pf3;
`endif
  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(1), .MDU_LAT(4)) d1 (
    .clk_i(clk), .rst_i(rst_n), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2), .ex_rd_i(rd), .ex_memread_i(mr),
    .ex_mdu_start_i(mdu), .ex_branch_taken_i(br), .pc_write_o(pc1),
    .ifid_write_o(iw1), .ifid_flush_o(fl1), .idex_bubble_o(bb1),
    .idex_hold_o(hd1), .exmem_bubble_o(eb1), .busy_o(by1)
`ifdef STALL_PERF_CNT_EN
    , .perf_load_stall_o(pl1), .perf_mdu_stall_o(pm1), .perf_flush_o(pf1)
`endif
  );
  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(3), .MDU_LAT(4)) d3 (
    .clk_i(clk), .rst_i(rst_n), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2), .ex_rd_i(rd), .ex_memread_i(mr),
    .ex_mdu_start_i(mdu), .ex_branch_taken_i(br), .pc_write_o(pc3),
    .ifid_write_o(iw3), .ifid_flush_o(fl3), .idex_bubble_o(bb3),
    .idex_hold_o(hd3), .exmem_bubble_o(eb3), .busy_o(by3)
`ifdef STALL_PERF_CNT_EN
    , .perf_load_stall_o(pl3), .perf_mdu_stall_o(pm3), .perf_flush_o(pf3)
`endif
  );
  // {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble, busy}
  assign o1 = {pc1, iw1, fl1, bb1, hd1, eb1, by1};
  assign o3 = {pc3, iw3, fl3, bb3, hd3, eb3, by3};
  localparam logic [6:0] NORM  = 7'b1100000;
  localparam logic [6:0] LD0   = 7'b0001000;
  localparam logic [6:0] LDW   = 7'b0001001;
  localparam logic [6:0] MDU0  = 7'b0000110;
  localparam logic [6:0] MDUW  = 7'b0000111;
  localparam logic [6:0] FLUSH = 7'b1111000;
  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic m, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic a1, input logic a2,
                     input logic md, input logic b);
    mr = m; rd = d; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2; mdu = md; br = b;
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_d1", o1, NORM);
    chk("reset_d3", o3, NORM);
    @(negedge clk) rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_d1", o1, NORM);
    chk("idle_d3", o3, NORM);
    // load-use on rs1; branch in the following cycle must not disturb LOAD_WAIT
    @(negedge clk) drv(1, 5, 5, 0, 1, 0, 0, 0);
    chk("lu_c1_d1", o1, LD0);
    chk("lu_c1_d3", o3, LD0);
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 0, 1);
    chk("lu_c2_br_d1", o1, FLUSH);
    chk("lu_c2_br_d3", o3, LDW);
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_c3_d1", o1, NORM);
    chk("lu_c3_d3", o3, LDW);
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_c4_d3", o3, NORM);
    // x0 destination and unused rs2 never stall
    @(negedge clk) drv(1, 0, 3, 0, 0, 1, 0, 0);
    chk("x0_d1", o1, NORM);
    chk("x0_d3", o3, NORM);
    @(negedge clk) drv(1, 7, 3, 7, 0, 0, 0, 0);
    chk("rs2unused_d1", o1, NORM);
    chk("rs2unused_d3", o3, NORM);
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("nostall_after_d3", o3, NORM);
    // MDU start pulse: hold for MDU_LAT-1 = 3 cycles
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 1, 0);
    chk("mdu_c1_d1", o1, MDU0);
    chk("mdu_c1_d3", o3, MDU0);
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mdu_c2_d1", o1, MDUW);
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mdu_c3_d1", o1, MDUW);
    chk("mdu_c3_d3", o3, MDUW);
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mdu_c4_d1", o1, NORM);
    chk("mdu_c4_d3", o3, NORM);
    // taken branch beats a coincident load-use hazard (rs2 match)
    @(negedge clk) drv(1, 9, 0, 9, 0, 1, 0, 1);
    chk("br_lu_d1", o1, FLUSH);
    chk("br_lu_d3", o3, FLUSH);
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_after_d3", o3, NORM);
    // reset asserted in 2nd LOAD_WAIT cycle with the hazard still on the inputs
    @(negedge clk) drv(1, 4, 0, 4, 0, 1, 0, 0);
    chk("rst_lu_c1_d3", o3, LD0);
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_lu_c2_d3", o3, LDW);
    @(negedge clk) drv(1, 4, 0, 4, 0, 1, 0, 0);
    chk("rst_lu_c3_d3", o3, LDW);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_d3", o3, NORM);
    chk("rst_mid_d1", o1, NORM);
    @(negedge clk) rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_idle_d3", o3, NORM);
    @(negedge clk) drv(1, 12, 12, 0, 1, 0, 0, 0);
    chk("post_rst_c1_d3", o3, LD0);
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_c2_d3", o3, LDW);
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_c3_d3", o3, LDW);
    @(negedge clk) drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_c4_d3", o3, NORM);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
